narrow_packer: RTL and testbench
================================

Name: narrow_packer

Overview:
- Streaming narrowing unit, the inverse of the sign/zero-extension path: accepts IN_W-bit words, narrows each to NW bits (signed or unsigned), and packs LANES narrowed values into one output word.
- Out-of-range values saturate and are flagged per lane.
- Sits between a wide datapath producer and a narrow-storage or bus consumer; valid/ready on both sides.

Parameters:
- IN_W, 8, input element width (> NW)
- NW, 4, narrowed element width
- LANES, 2, narrowed elements per output word; output width NW*LANES

Ports:
- clk  input  1  clock, rising-edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  input element valid
- in_ready  output  1  input element accepted when in_valid && in_ready
- in_data  input  IN_W  element to narrow
- in_signed  input  1  1: two's-complement interpretation; 0: unsigned; sampled per beat
- in_last  input  1  final element of a packet; flushes a partial word
- out_valid  output  1  packed word valid
- out_ready  input  1  consumer accepts when out_valid && out_ready
- out_data  output  NW*LANES  packed word, lane 0 in bits [NW-1:0]
- out_count  output  $clog2(LANES)+1  number of valid lanes (1..LANES)
- out_ovf  output  LANES  per-lane saturation flag

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_count=0, out_ovf=0, lane counter=0, accumulator cleared. in_ready reads 1 during reset. A partially filled word is discarded.
- Narrowing, signed: legal range -2^(NW-1)..2^(NW-1)-1. Above range gives 0111..1 with ovf=1; below range gives 1000..0 with ovf=1; in range gives the low NW bits with ovf=0.
- Narrowing, unsigned: legal range 0..2^NW-1. Above range gives all ones with ovf=1; otherwise the low NW bits.
- Accumulator: lane counter idx runs 0..LANES-1. Each accepted beat writes lane idx and its ovf bit.
- Completion: a beat completes the word when idx==LANES-1 or in_last=1.
  - Non-completing beat: idx increments.
  - Completing beat: on the same edge the accumulated lanes plus the current lane load the output register. out_valid=1 next cycle (latency 1). out_count=idx+1. idx returns to 0 and the accumulator clears.
- Unfilled lanes in a flushed word are 0 with ovf=0.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational). This allows a full-throughput new load in the same cycle as an output handshake.
  - out_valid falls after a handshake unless a new word loads on the same edge.
  - out_data, out_count and out_ovf hold stable while out_valid && !out_ready.
- States: FILL (idx < LANES, out register empty or draining) and HOLD (out_valid && !out_ready). in_ready=0 in HOLD. No beat is accepted or lost while stalled.
- in_last on the first lane gives out_count=1. in_valid && !in_ready leaves state unchanged.

Optional Feature:
- Macro NARROW_PACKER_STATS_EN.
- Defined:
  - Extra output port ovf_total [15:0].
  - Counts saturated elements, +1 per accepted beat whose narrowed lane overflowed.
  - Saturates at 16'hFFFF (no wrap). Reset to 0 by rst_n.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package narrow_pkg: default IN_W/NW/LANES constants, count-width constant, saturation bound constants (SMAX, SMIN, UMAX) as functions of NW.
- Sub-module narrow_sat: purely combinational single-element narrower (in_data, in_signed -> nw_data, ovf).
- narrow_packer instantiates one narrow_sat and owns the counter, accumulator, output register and handshake.

Test Plan:
- Signed narrowing:
  - in_signed=1, 8'hF9 then 8'h09, out_ready=1 -> out_data=8'h79, out_count=2, out_ovf=2'b10.
  - in_signed=1, 8'h80 -> lane value 4'h8, ovf=1.
- Unsigned narrowing: in_signed=0, 8'h09 then 8'hF9 -> out_data=8'hF9, out_ovf=2'b10. 8'h0F is in range -> 4'hF, ovf=0.
- Flush: single beat 8'h03, in_last=1, signed -> out_data=8'h03, out_count=1, out_ovf=2'b00 one cycle later.
- Backpressure: out_ready=0 after word 8'hE3 forms -> in_ready=0. Output holds 8'hE3 for 5 cycles. Raising out_ready yields exactly one handshake and no lost beats.
- Throughput: continuous in_valid with out_ready=1 over 8 beats (signed, values -2..5) -> 4 words, one every 2 cycles, no stall cycles.
- Reset mid-operation: rst_n low after lane 0 accepted -> out_valid=0 immediately. After release, first word contains only post-reset beats. With NARROW_PACKER_STATS_EN, ovf_total=0.

Source files
------------

// File: rtl/narrow_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : narrow_pkg
//  Description : Shared constants, state encoding and saturation-bound
//                helpers for the narrow_packer block.
//                Optional feature macro NARROW_PACKER_STATS_EN is consumed by
//                narrow_packer (adds the ovf_total port).
//  Revision    : 1.0 - initial release
// ============================================================================
package narrow_pkg;

    // Default configuration
    localparam int c_IN_W  = 8;
    localparam int c_NW    = 4;
    localparam int c_LANES = 2;

    // Width of the lane counter / out_count field
    function automatic int cnt_w(input int lanes);
        return $clog2(lanes) + 1;
    endfunction

    // Saturation bounds as functions of the narrowed width
    function automatic int smax(input int nw);
        return (1 << (nw - 1)) - 1;
    endfunction

    function automatic int smin(input int nw);
        return -(1 << (nw - 1));
    endfunction

    function automatic int umax(input int nw);
        return (1 << nw) - 1;
    endfunction

    // FILL: output register empty (can take a new word)
    // HOLD: output register occupied; stalls input when out_ready is low
    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } np_state_t;

endpackage : narrow_pkg
`default_nettype wire

// File: rtl/narrow_sat.sv
`default_nettype none
// ============================================================================
//  Module      : narrow_sat
//  Description : Combinational single-element narrower with saturation.
//  Ports       : in_data   [IN_W-1:0] element to narrow
//                in_signed            1: two's complement, 0: unsigned
//                nw_data   [NW-1:0]   narrowed (possibly saturated) value
//                ovf                  1 when the value was out of range
//  Revision    : 1.0 - initial release
// ============================================================================
module narrow_sat
    import narrow_pkg::*;
#(
    parameter int IN_W = c_IN_W,
    parameter int NW   = c_NW
) (
    input  logic [IN_W-1:0] in_data,
    input  logic            in_signed,
    output logic [NW-1:0]   nw_data,
    output logic            ovf
);

    localparam logic [NW-1:0] c_SMAX = NW'(smax(NW));
    localparam logic [NW-1:0] c_SMIN = NW'(smin(NW));
    localparam logic [NW-1:0] c_UMAX = NW'(umax(NW));

    // A signed value fits in NW bits when every bit from the narrowed sign
    // position upward is a copy of the same value.
    logic [IN_W-NW:0] w_hi_s;
    logic             w_s_fit;
    logic             w_u_fit;

    assign w_hi_s  = in_data[IN_W-1:NW-1];
    assign w_s_fit = (&w_hi_s) || !(|w_hi_s);
    assign w_u_fit = !(|in_data[IN_W-1:NW]);

    always_comb begin
        nw_data = in_data[NW-1:0];
        ovf     = 1'b0;
        if (in_signed) begin
            if (!w_s_fit) begin
                ovf     = 1'b1;
                nw_data = in_data[IN_W-1] ? c_SMIN : c_SMAX;
            end
        end else if (!w_u_fit) begin
            ovf     = 1'b1;
            nw_data = c_UMAX;
        end
    end

endmodule : narrow_sat
`default_nettype wire

// File: rtl/narrow_packer.sv
`default_nettype none
// ============================================================================
//  Module      : narrow_packer
//  Description : Streaming narrower. Narrows IN_W-bit elements to NW bits
//                (signed or unsigned, saturating) and packs LANES of them
//                into one output word. in_last flushes a partial word.
//  Ports       : clk, rst_n (async, active low)
//                in_valid/in_ready/in_data/in_signed/in_last  input stream
//                out_valid/out_ready/out_data/out_count/out_ovf output stream
//                ovf_total [15:0] saturated-element count (only when
//                NARROW_PACKER_STATS_EN is defined)
//  Revision    : 1.0 - initial release
// ============================================================================
module narrow_packer
    import narrow_pkg::*;
#(
    parameter int IN_W  = c_IN_W,
    parameter int NW    = c_NW,
    parameter int LANES = c_LANES
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN_W-1:0]         in_data,
    input  logic                    in_signed,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NW*LANES-1:0]     out_data,
    output logic [$clog2(LANES):0]  out_count,
    output logic [LANES-1:0]        out_ovf
`ifdef NARROW_PACKER_STATS_EN
    ,
    output logic [15:0]             ovf_total
`endif
);

    localparam int c_CW = cnt_w(LANES);

    np_state_t             r_state;
    np_state_t             w_state_nxt;
    logic [c_CW-1:0]       r_idx;
    logic [NW*LANES-1:0]   r_acc;
    logic [LANES-1:0]      r_acc_ovf;
    logic [NW*LANES-1:0]   r_out_data;
    logic [c_CW-1:0]       r_out_count;
    logic [LANES-1:0]      r_out_ovf;

    logic [NW-1:0]         w_nw;
    logic                  w_ovf;
    logic [NW*LANES-1:0]   w_word;
    logic [LANES-1:0]      w_word_ovf;
    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_complete;
    logic                  w_load;

    narrow_sat #(
        .IN_W (IN_W),
        .NW   (NW)
    ) u_sat (
        .in_data   (in_data),
        .in_signed (in_signed),
        .nw_data   (w_nw),
        .ovf       (w_ovf)
    );

    // Input is blocked only while a word sits unconsumed in the output
    // register; a draining word frees the slot for a same-edge reload.
    assign w_in_ready = (r_state == ST_FILL) || out_ready;
    assign w_accept   = in_valid && w_in_ready;
    assign w_complete = in_last || (r_idx == c_CW'(LANES - 1));
    assign w_load     = w_accept && w_complete;

    // Current accumulator with the incoming lane merged in. Lanes above idx
    // are already zero because the accumulator clears on every completion.
    always_comb begin
        w_word     = r_acc;
        w_word_ovf = r_acc_ovf;
        for (int l = 0; l < LANES; l++) begin
            if (r_idx == c_CW'(l)) begin
                w_word[l*NW +: NW] = w_nw;
                w_word_ovf[l]      = w_ovf;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FILL: begin
                if (w_load) w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready && !w_load) w_state_nxt = ST_FILL;
            end
            default: w_state_nxt = ST_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_FILL;
            r_idx       <= '0;
            r_acc       <= '0;
            r_acc_ovf   <= '0;
            r_out_data  <= '0;
            r_out_count <= '0;
            r_out_ovf   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                if (w_complete) begin
                    r_out_data  <= w_word;
                    r_out_count <= r_idx + c_CW'(1);
                    r_out_ovf   <= w_word_ovf;
                    r_idx       <= '0;
                    r_acc       <= '0;
                    r_acc_ovf   <= '0;
                end else begin
                    r_idx     <= r_idx + c_CW'(1);
                    r_acc     <= w_word;
                    r_acc_ovf <= w_word_ovf;
                end
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = (r_state == ST_HOLD);
    assign out_data  = r_out_data;
    assign out_count = r_out_count;
    assign out_ovf   = r_out_ovf;

`ifdef NARROW_PACKER_STATS_EN
    logic [15:0] r_ovf_total;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_total <= '0;
        end else if (w_accept && w_ovf && (r_ovf_total != 16'hFFFF)) begin
            r_ovf_total <= r_ovf_total + 16'd1;
        end
    end

    assign ovf_total = r_ovf_total;
`endif

endmodule : narrow_packer
`default_nettype wire

// File: tb/tb_narrow_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_narrow_packer
//  Description : Self-checking bench for narrow_packer (default parameters).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_narrow_packer;

    localparam int LANES = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_signed;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] out_count;
    logic [1:0] out_ovf;
`ifdef NARROW_PACKER_STATS_EN
    logic [15:0] ovf_total;
`endif

    narrow_packer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_signed (in_signed),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_ovf   (out_ovf)
`ifdef NARROW_PACKER_STATS_EN
        ,
        .ovf_total (ovf_total)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int hs_count = 0;
    int stalls   = 0;

    typedef struct {
        logic [7:0] data;
        logic [1:0] cnt;
        logic [1:0] ovf;
    } word_t;

    word_t exp_q[$];
    int    m_val[LANES];
    bit    m_ovf[LANES];
    int    m_n = 0;
    int    m_ovf_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference narrowing from the range rules, using plain integers.
    function automatic void narrow_ref(input logic [7:0] d, input bit s, output int v, output bit o);
        int x;
        o = 1'b0;
        if (s) begin
            x = $signed(d);
            if (x > 7)       begin v = 7;  o = 1'b1; end
            else if (x < -8) begin v = -8; o = 1'b1; end
            else             v = x;
        end else begin
            x = int'(d);
            if (x > 15) begin v = 15; o = 1'b1; end
            else        v = x;
        end
        v = v & 15;
    endfunction

    task automatic model_accept(input logic [7:0] d, input bit s, input bit l);
        int v;
        bit o;
        int w;
        int ov;
        word_t wd;
        narrow_ref(d, s, v, o);
        m_val[m_n] = v;
        m_ovf[m_n] = o;
        if (o && m_ovf_total < 65535) m_ovf_total++;
        m_n++;
        if (m_n == LANES || l) begin
            w = 0;
            ov = 0;
            for (int i = 0; i < m_n; i++) begin
                w  = w | (m_val[i] << (4 * i));
                ov = ov | (int'(m_ovf[i]) << i);
            end
            wd.data = 8'(w);
            wd.cnt  = 2'(m_n);
            wd.ovf  = 2'(ov);
            exp_q.push_back(wd);
            m_n = 0;
        end
    endtask

    // Called #1 after the negedge: the handshakes seen here take effect on
    // the following rising edge.
    task automatic monitor();
        word_t wd;
        if (out_valid === 1'b1 && out_ready) begin
            hs_count++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL spurious_word observed=%0h expected=none", out_data);
            end else begin
                wd = exp_q.pop_front();
                check("word_data",  out_data,  wd.data);
                check("word_count", out_count, wd.cnt);
                check("word_ovf",   out_ovf,   wd.ovf);
            end
        end
        if (in_valid && in_ready === 1'b1) model_accept(in_data, in_signed, in_last);
    endtask

    task automatic cycle(input bit v, input logic [7:0] d, input bit s, input bit l,
                         input bit r, output bit acc);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_signed = s;
        in_last   = l;
        out_ready = r;
        #1;
        acc = v && (in_ready === 1'b1);
        monitor();
    endtask

    task automatic idle(input bit r);
        bit acc;
        cycle(1'b0, 8'h00, 1'b0, 1'b0, r, acc);
    endtask

    task automatic send(input logic [7:0] d, input bit s, input bit l, input bit r);
        bit acc;
        int n;
        n = 0;
        do begin
            cycle(1'b1, d, s, l, r, acc);
            n++;
        end while (!acc && n < 64);
        stalls += n - 1;
        if (!acc) begin
            total++;
            bad++;
            $error("FAIL send_timeout observed=not_accepted expected=accepted data=%0h", d);
        end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int hs0;
        bit rv, rs, rl, rr;
        logic [7:0] rd;

        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; in_signed = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data,  0);
        check("rst_out_count", out_count, 0);
        check("rst_out_ovf",   out_ovf,   0);
        check("rst_in_ready",  in_ready,  1);
`ifdef NARROW_PACKER_STATS_EN
        check("rst_ovf_total", ovf_total, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Signed pair: -7 in range, +9 saturates to +7
        send(8'hF9, 1, 0, 1);
        send(8'h09, 1, 0, 1);
        idle(1);
        check("s_valid", out_valid, 1);
        check("s_data",  out_data,  8'h79);
        check("s_count", out_count, 2);
        check("s_ovf",   out_ovf,   2'b10);
        idle(1);
        check("s_valid_fall", out_valid, 0);

        // Signed -128 saturates to 4'h8
        send(8'h80, 1, 1, 1);
        idle(1);
        check("smin_data", out_data, 8'h08);
        check("smin_ovf",  out_ovf,  2'b01);

        // Unsigned: 9 in range, 0xF9 saturates
        send(8'h09, 0, 0, 1);
        send(8'hF9, 0, 0, 1);
        idle(1);
        check("u_data", out_data, 8'hF9);
        check("u_ovf",  out_ovf,  2'b10);
        send(8'h0F, 0, 1, 1);
        idle(1);
        check("u_edge_data", out_data, 8'h0F);
        check("u_edge_ovf",  out_ovf,  2'b00);

        // Flush on first lane, latency 1
        send(8'h03, 1, 1, 1);
        check("flush_pre_valid", out_valid, 0);
        idle(1);
        check("flush_valid", out_valid, 1);
        check("flush_data",  out_data,  8'h03);
        check("flush_count", out_count, 1);
        check("flush_ovf",   out_ovf,   2'b00);

        // Backpressure: word E3 held 5 cycles with a pending beat
        send(8'h03, 1, 0, 0);
        send(8'hFE, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 8'h01, 1, 0, 0, acc);
            check("bp_in_ready",  in_ready,  0);
            check("bp_out_valid", out_valid, 1);
            check("bp_hold_data", out_data,  8'hE3);
            check("bp_hold_cnt",  out_count, 2);
        end
        hs0 = hs_count;
        cycle(1, 8'h01, 1, 0, 1, acc);
        check("bp_release_acc", acc, 1);
        idle(1);
        check("bp_one_hs",    hs_count, hs0 + 1);
        check("bp_valid_fall", out_valid, 0);
        send(8'h02, 1, 1, 1);
        idle(1);
        check("bp_next_data", out_data, 8'h21);

        // Throughput: 8 back-to-back beats, values -2..5
        stalls = 0;
        hs0 = hs_count;
        for (int v = -2; v <= 5; v++) send(8'(v), 1, 0, 1);
        idle(1);
        idle(1);
        check("tp_stalls", stalls, 0);
        check("tp_words",  hs_count, hs0 + 4);

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            rv = ($urandom_range(0, 3) != 0);
            rd = 8'($urandom);
            rs = 1'($urandom);
            rl = ($urandom_range(0, 4) == 0);
            rr = ($urandom_range(0, 3) != 0);
            cycle(rv, rd, rs, rl, rr, acc);
        end
        send(8'h00, 1, 1, 1);
        for (int i = 0; i < 4; i++) idle(1);
        check("rand_drained", exp_q.size(), 0);
`ifdef NARROW_PACKER_STATS_EN
        check("stats_total", ovf_total, m_ovf_total);
`endif

        // Reset with lane 0 (an overflowing one) in the accumulator
        send(8'h9A, 0, 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mrst_valid", out_valid, 0);
        check("mrst_data",  out_data,  0);
        check("mrst_count", out_count, 0);
        check("mrst_ready", in_ready,  1);
`ifdef NARROW_PACKER_STATS_EN
        check("mrst_ovf_total", ovf_total, 0);
`endif
        exp_q.delete();
        m_n = 0;
        m_ovf_total = 0;
        idle(1);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h04, 1, 0, 1);
        send(8'h05, 1, 0, 1);
        idle(1);
        check("post_rst_data",  out_data,  8'h54);
        check("post_rst_count", out_count, 2);
        idle(1);
`ifdef NARROW_PACKER_STATS_EN
        check("post_rst_stats", ovf_total, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_narrow_packer
`default_nettype wire
